// File: rtl/port_merge_arb.sv
`timescale 1ns/1ps
// port_merge_arb: packet-granular round-robin merge of NPORT SOF/EOF-framed beat streams
// onto one registered output. Define PORT_MERGE_ARB_STAT_EN to add per-port STAT_PKT counters.
module port_merge_arb #(
  parameter int NPORT = 4,
  parameter int WORDS = 8
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NPORT-1:0][WORDS-1:0][63:0] D,
  input  logic [NPORT-1:0]                  D_VALID,
  input  logic [NPORT-1:0]                  D_SOF,
  input  logic [NPORT-1:0]                  D_EOF,
  output logic [NPORT-1:0]                  D_BP,
  output logic [WORDS-1:0][63:0]            Q,
  output logic                              Q_VALID,
  output logic                              Q_SOF,
  output logic                              Q_EOF,
  input  logic                              Q_BP,
  output logic [NPORT-1:0]                  GRANT,
  output logic                              ERR_SOF
`ifdef PORT_MERGE_ARB_STAT_EN
  ,
  output logic [NPORT-1:0][31:0]            STAT_PKT
`endif
);

  localparam int PW = $clog2(NPORT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic [NPORT-1:0]       grant_q, grant_d;
  logic [WORDS-1:0][63:0] q_q, q_d;
  logic                   q_valid_q, q_valid_d;
  logic                   q_sof_q, q_sof_d;
  logic                   q_eof_q, q_eof_d;
  logic                   err_sof_q, err_sof_d;

  logic                   out_ok_s;
  logic                   accept_s;
  logic [NPORT-1:0]       sof_req_s;
  logic [NPORT-1:0]       stray_s;
  logic [NPORT-1:0]       stray_oh_s;
  logic [2*NPORT-1:0]     req_dbl_s;
  logic [NPORT-1:0]       req_rot_s;
  logic [NPORT-1:0]       rot_oh_s;
  logic [PW-1:0]          off_s;
  logic [PW:0]            sum_s;
  logic                   hit_s;
  logic [PW-1:0]          hit_idx_s;

  assign out_ok_s   = ~q_valid_q | ~Q_BP;
  assign sof_req_s  = D_VALID & D_SOF;
  assign stray_s    = D_VALID & ~D_SOF;
  assign stray_oh_s = stray_s & (~stray_s + NPORT'(1'b1));

  // Round-robin search: rotate requests so PTR sits at bit 0, take the lowest set bit
  always_comb begin
    req_dbl_s = {sof_req_s, sof_req_s} >> ptr_q;
    req_rot_s = req_dbl_s[NPORT-1:0];
    rot_oh_s  = req_rot_s & (~req_rot_s + NPORT'(1'b1));
    hit_s     = |req_rot_s;
    off_s     = '0;
    for (int j = 0; j < NPORT; j++) begin
      off_s = off_s | (rot_oh_s[j] ? PW'(j) : '0);
    end
    sum_s     = {1'b0, ptr_q} + {1'b0, off_s};
    hit_idx_s = (sum_s >= (PW+1)'(NPORT)) ? PW'(sum_s - (PW+1)'(NPORT)) : sum_s[PW-1:0];
  end

  // Next-state, grant, backpressure and output-stage load
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    q_sof_d   = q_sof_q;
    q_eof_d   = q_eof_q;
    err_sof_d = 1'b0;
    accept_s  = 1'b0;
    D_BP      = '1;
    case (state_q)
      IDLE: begin
        // Only the lowest stray non-SOF beat is drained; SOF requesters wait for the grant
        D_BP      = ~stray_oh_s;
        err_sof_d = |stray_s;
        if (hit_s) begin
          state_d = BUSY;
          gidx_d  = hit_idx_s;
          grant_d = NPORT'(1'b1) << hit_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        D_BP     = ~(grant_q & {NPORT{out_ok_s}});
        accept_s = D_VALID[gidx_q] & out_ok_s;
        if (accept_s && D_EOF[gidx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (gidx_q == PW'(NPORT-1)) ? '0 : gidx_q + PW'(1);
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (accept_s) begin
      q_d       = D[gidx_q];
      q_valid_d = 1'b1;
      q_sof_d   = D_SOF[gidx_q];
      q_eof_d   = D_EOF[gidx_q];
    end else if (out_ok_s) begin
      q_valid_d = 1'b0;
    end else begin
      q_valid_d = q_valid_q;
    end
  end

  // State, pointer, grant and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_sof_q   <= 1'b0;
      q_eof_q   <= 1'b0;
      err_sof_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_sof_q   <= q_sof_d;
      q_eof_q   <= q_eof_d;
      err_sof_q <= err_sof_d;
    end
  end

  assign Q       = q_q;
  assign Q_VALID = q_valid_q;
  assign Q_SOF   = q_sof_q;
  assign Q_EOF   = q_eof_q;
  assign GRANT   = grant_q;
  assign ERR_SOF = err_sof_q;

`ifdef PORT_MERGE_ARB_STAT_EN
  logic [NPORT-1:0][31:0] stat_q;

  // Per-port packet counters, bumped on each accepted EOF beat; wrap at 2^32
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_q <= '0;
    end else if (accept_s && D_EOF[gidx_q]) begin
      stat_q[gidx_q] <= stat_q[gidx_q] + 32'd1;
    end else begin
      stat_q <= stat_q;
    end
  end

  assign STAT_PKT = stat_q;
`endif

endmodule

// File: tb/tb_port_merge_arb.sv
`timescale 1ns/1ps
// Directed self-checking bench for port_merge_arb: per-port beat queues drive the inputs,
// transferred output beats and per-cycle signal logs are compared against hand-derived values.
module tb_port_merge_arb;

  localparam int NPORT = 4;
  localparam int WORDS = 8;

  typedef struct packed {
    logic [511:0] data;
    logic         sof;
    logic         eof;
  } beat_t;

  logic                              CLK;
  logic                              RST;
  logic [NPORT-1:0][WORDS-1:0][63:0] D;
  logic [NPORT-1:0]                  D_VALID;
  logic [NPORT-1:0]                  D_SOF;
  logic [NPORT-1:0]                  D_EOF;
  logic [NPORT-1:0]                  D_BP;
  logic [WORDS-1:0][63:0]            Q;
  logic                              Q_VALID;
  logic                              Q_SOF;
  logic                              Q_EOF;
  logic                              Q_BP;
  logic [NPORT-1:0]                  GRANT;
  logic                              ERR_SOF;
`ifdef PORT_MERGE_ARB_STAT_EN
  logic [NPORT-1:0][31:0]            STAT_PKT;
`endif

  port_merge_arb #(.NPORT(NPORT), .WORDS(WORDS)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .D       (D),
    .D_VALID (D_VALID),
    .D_SOF   (D_SOF),
    .D_EOF   (D_EOF),
    .D_BP    (D_BP),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .Q_SOF   (Q_SOF),
    .Q_EOF   (Q_EOF),
    .Q_BP    (Q_BP),
    .GRANT   (GRANT),
    .ERR_SOF (ERR_SOF)
`ifdef PORT_MERGE_ARB_STAT_EN
    ,
    .STAT_PKT(STAT_PKT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int               n_checks;
  int               n_fail;
  beat_t            pq [NPORT][$];
  beat_t            oq [$];
  logic [63:0]      qv_bits;
  logic [63:0]      err_bits;
  logic [63:0]      qbp_bits;
  logic [NPORT-1:0] gnt_log [64];
  logic [NPORT-1:0] bp_log  [64];
  logic [511:0]     q_log   [64];
  int               cyc;

  task automatic chk(input string tag, input logic [519:0] act, input logic [519:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] w0, input logic sof, input logic eof);
    beat_t b;
    b.data = {448'd0, w0};
    b.sof  = sof;
    b.eof  = eof;
    return b;
  endfunction

  task automatic clr_logs();
    oq.delete();
    qv_bits  = '0;
    err_bits = '0;
    qbp_bits = '0;
    cyc      = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NPORT; i++) pq[i].delete();
    RST     = 1'b1;
    Q_BP    = 1'b0;
    D       = '0;
    D_VALID = '0;
    D_SOF   = '0;
    D_EOF   = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    clr_logs();
  endtask

  // One cycle per iteration: present queue heads, log outputs, pop heads that transferred
  task automatic run(input int n);
    logic [NPORT-1:0] v;
    beat_t            b;
    for (int c = 0; c < n; c++) begin
      Q_BP = qbp_bits[cyc];
      for (int i = 0; i < NPORT; i++) begin
        if (pq[i].size() > 0) begin
          D[i]       = pq[i][0].data;
          D_VALID[i] = 1'b1;
          D_SOF[i]   = pq[i][0].sof;
          D_EOF[i]   = pq[i][0].eof;
        end else begin
          D[i]       = '0;
          D_VALID[i] = 1'b0;
          D_SOF[i]   = 1'b0;
          D_EOF[i]   = 1'b0;
        end
      end
      #1;
      qv_bits[cyc]  = Q_VALID;
      err_bits[cyc] = ERR_SOF;
      gnt_log[cyc]  = GRANT;
      bp_log[cyc]   = D_BP;
      q_log[cyc]    = Q;
      if (Q_VALID && !Q_BP) begin
        b.data = Q;
        b.sof  = Q_SOF;
        b.eof  = Q_EOF;
        oq.push_back(b);
      end
      v = D_VALID & ~D_BP;
      @(posedge CLK); #1;
      for (int i = 0; i < NPORT; i++) begin
        if (v[i]) void'(pq[i].pop_front());
      end
      cyc++;
    end
  endtask

  task automatic chk_out(input string tag, input int k, input beat_t e);
    chk(tag, (k < oq.size()) ? oq[k] : {514{1'b1}}, e);
  endtask

  logic [WORDS-1:0][63:0] w;
  beat_t                  b0, b1, bx;
  int                     holds;
  logic                   bp_all;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset values
    do_reset();
    chk("rst_q", Q, 512'd0);
    chk("rst_qv", Q_VALID, 1'b0);
    chk("rst_sof_eof", {Q_SOF, Q_EOF}, 2'b00);
    chk("rst_grant", GRANT, 4'b0000);
    chk("rst_err", ERR_SOF, 1'b0);
    chk("rst_dbp", D_BP, 4'b1111);
`ifdef PORT_MERGE_ARB_STAT_EN
    chk("rst_stat", STAT_PKT, 128'd0);
`endif

    // 1: two-beat packet on port 0
    w = '0; w[7] = 64'd5;
    b0.data = w; b0.sof = 1'b1; b0.eof = 1'b0;
    w = '0;
    for (int i = 1; i <= 5; i++) w[i] = 64'(i);
    b1.data = w; b1.sof = 1'b0; b1.eof = 1'b1;
    pq[0].push_back(b0);
    pq[0].push_back(b1);
    run(5);
    chk("t1_qv", qv_bits[4:0], 5'b01100);
    chk("t1_bp_wait", bp_log[0][0], 1'b1);
    chk("t1_bp_go", bp_log[1][0], 1'b0);
    chk("t1_gnt", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 16'h0110);
    chk("t1_n", oq.size(), 2);
    chk_out("t1_b0", 0, b0);
    chk_out("t1_b1", 1, b1);

    // 2: four single-beat packets at once, then fairness after port 0 EOF
    do_reset();
    for (int i = 0; i < NPORT; i++) pq[i].push_back(mk(64'h10 + 64'(i), 1'b1, 1'b1));
    run(10);
    chk("t2_qv", qv_bits[9:0], 10'b01_0101_0100);
    chk("t2_n", oq.size(), 4);
    for (int i = 0; i < NPORT; i++) chk_out("t2_order", i, mk(64'h10 + 64'(i), 1'b1, 1'b1));
    clr_logs();
    pq[0].push_back(mk(64'hA0, 1'b1, 1'b1));
    pq[0].push_back(mk(64'hA1, 1'b1, 1'b1));
    pq[3].push_back(mk(64'hA3, 1'b1, 1'b1));
    run(8);
    chk("t2_ptr_wrap", gnt_log[1], 4'b0001);
    chk("t2_fair_gnt", gnt_log[3], 4'b1000);
    chk_out("t2_fair0", 0, mk(64'hA0, 1'b1, 1'b1));
    chk_out("t2_fair1", 1, mk(64'hA3, 1'b1, 1'b1));
    chk_out("t2_fair2", 2, mk(64'hA1, 1'b1, 1'b1));

    // 3: port 2 requests while port 1 is mid-packet
    do_reset();
    pq[1].push_back(mk(64'h100, 1'b1, 1'b0));
    pq[1].push_back(mk(64'h101, 1'b0, 1'b0));
    pq[1].push_back(mk(64'h102, 1'b0, 1'b1));
    run(2);
    pq[2].push_back(mk(64'h200, 1'b1, 1'b0));
    pq[2].push_back(mk(64'h201, 1'b0, 1'b1));
    run(8);
    chk("t3_qv", qv_bits[9:0], 10'b00_1101_1100);
    chk("t3_bp2_held", bp_log[3][2], 1'b1);
    chk("t3_n", oq.size(), 5);
    chk_out("t3_o0", 0, mk(64'h100, 1'b1, 1'b0));
    chk_out("t3_o2", 2, mk(64'h102, 1'b0, 1'b1));
    chk_out("t3_o3", 3, mk(64'h200, 1'b1, 1'b0));
    chk_out("t3_o4", 4, mk(64'h201, 1'b0, 1'b1));

    // 4: downstream backpressure for 5 cycles while beat 2 sits in Q
    do_reset();
    for (int k = 0; k < 4; k++) pq[0].push_back(mk(64'h400 + 64'(k), k == 0, k == 3));
    qbp_bits = 64'hF8;
    run(12);
    holds  = 0;
    bp_all = 1'b1;
    for (int c = 3; c <= 7; c++) begin
      if (q_log[c] == mk(64'h401, 1'b0, 1'b0).data && qv_bits[c]) holds++;
      bp_all = bp_all & bp_log[c][0];
    end
    chk("t4_hold_cycles", holds, 5);
    chk("t4_bp_granted", bp_all, 1'b1);
    chk("t4_n", oq.size(), 4);
    for (int k = 0; k < 4; k++) chk_out("t4_beat", k, mk(64'h400 + 64'(k), k == 0, k == 3));

    // 5: stray non-SOF beats while idle
    do_reset();
    pq[3].push_back(mk(64'h33, 1'b0, 1'b0));
    run(4);
    chk("t5_err", err_bits[3:0], 4'b0010);
    chk("t5_qv", qv_bits[3:0], 4'b0000);
    chk("t5_consumed", pq[3].size(), 0);
    clr_logs();
    pq[1].push_back(mk(64'h11, 1'b0, 1'b0));
    pq[2].push_back(mk(64'h22, 1'b0, 1'b0));
    run(4);
    chk("t5_low_first", bp_log[0], 4'b1101);
    chk("t5_err2", err_bits[3:0], 4'b0110);

    // 6: reset during beat 2 of a 4-beat packet, then a fresh packet
    do_reset();
    for (int k = 0; k < 4; k++) pq[0].push_back(mk(64'h600 + 64'(k), k == 0, k == 3));
    run(3);
    RST = 1'b1;
    run(1);
    RST = 1'b0;
    chk("t6_qv_rst", Q_VALID, 1'b0);
    chk("t6_gnt_rst", GRANT, 4'b0000);
`ifdef PORT_MERGE_ARB_STAT_EN
    chk("t6_stat_rst", STAT_PKT[0], 32'd0);
`endif
    pq[0].delete();
    oq.delete();
    bx = mk(64'h6A, 1'b1, 1'b0);
    pq[0].push_back(bx);
    pq[0].push_back(mk(64'h6B, 1'b0, 1'b1));
    run(5);
    chk("t6_qv", qv_bits[8:4], 5'b01100);
    chk("t6_n", oq.size(), 2);
    chk_out("t6_b0", 0, bx);
    chk_out("t6_b1", 1, mk(64'h6B, 1'b0, 1'b1));
`ifdef PORT_MERGE_ARB_STAT_EN
    chk("t6_stat_one", STAT_PKT[0], 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
